// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the button debouncer.
// Holds the FSM state encoding, parameter defaults and the legal
// minimum/maximum values the debouncer parameters are expected to respect.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;
    localparam int DEBOUNCE_CYCLES_MIN = 2;

endpackage

// File: rtl/button_debounce_sync_ff.sv
// N-stage flop synchronizer for a single asynchronous bit.
// RST_VAL sets the value every stage takes during reset, so the chain can
// idle at the input's inactive level and never present a false edge.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; the oldest bit is the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes btn_raw, then requires DEBOUNCE_CYCLES
// consecutive identical samples before committing a new level. Produces a
// registered level plus one-cycle rise/fall strobes.
// Optional macro BUTTON_DEBOUNCE_INVERT_EN: btn_raw is active-low (pull-up
// button); synchronizer idles at 1 and the sample is inverted before the FSM.
//
// Handshake: none. rise/fall are single-cycle strobes, never high together
// and never in consecutive cycles; consumers need no acknowledge.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   btn_raw,
    output logic   level,
    output logic   rise,
    output logic   fall,
    output state_e dbg_state
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_DEBOUNCE_INVERT_EN
    localparam logic RAW_IDLE = 1'b1;
`else
    localparam logic RAW_IDLE = 1'b0;
`endif

    logic          s_sync;
    logic          s;
    state_e        state;
    logic [CW-1:0] cnt;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RAW_IDLE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_raw),
        .q       (s_sync)
    );

    // Normalize the synchronized sample so the FSM always sees 1 = pressed.
`ifdef BUTTON_DEBOUNCE_INVERT_EN
    assign s = ~s_sync;
`else
    assign s = s_sync;
`endif

    // Debounce FSM with qualifying counter and registered outputs. The first
    // differing sample counts as sample 1; any bounce back drops all progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        state <= CHK_HI;
                        cnt   <= CW'(1);
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state <= CHK_LO;
                        cnt   <= CW'(1);
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        level <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Stimulus is expressed as "pressed" and mapped to the raw pin polarity,
// so the same vectors serve the BUTTON_DEBOUNCE_INVERT_EN build.
module tb_button_debounce;
    import debounce_pkg::*;

`ifdef BUTTON_DEBOUNCE_INVERT_EN
    localparam logic RAW_INV = 1'b1;
`else
    localparam logic RAW_INV = 1'b0;
`endif

    typedef struct {
        logic btn;
        logic exp_level;
        logic exp_rise;
        logic exp_fall;
    } vec_t;

    logic   clk;
    logic   reset_n;
    logic   btn_raw;
    logic   level;
    logic   rise;
    logic   fall;
    state_e dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[$];

    button_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_outs(input string name, input logic l, input logic r, input logic f);
        check({name, ".level"}, {1'b0, level}, {1'b0, l});
        check({name, ".rise"},  {1'b0, rise},  {1'b0, r});
        check({name, ".fall"},  {1'b0, fall},  {1'b0, f});
    endtask

    task automatic press(input logic p);
        btn_raw = p ^ RAW_INV;
    endtask

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_one(input logic b, input logic l, input logic r, input logic f);
        vec_t v;
        v.btn = b; v.exp_level = l; v.exp_rise = r; v.exp_fall = f;
        vecs.push_back(v);
    endtask

    task automatic add_run(input logic b, input int n, input logic l);
        for (int i = 0; i < n; i++) add_one(b, l, 1'b0, 1'b0);
    endtask

    initial begin
        // Vector i: btn applied before edge i, outputs checked just after it.
        // Clean press: rise at relative edge 5.
        add_run(1'b1, 5, 1'b0); add_one(1'b1, 1'b1, 1'b1, 1'b0); add_run(1'b1, 2, 1'b1);
        // Release: fall at relative edge 5.
        add_run(1'b0, 5, 1'b1); add_one(1'b0, 1'b0, 1'b0, 1'b1); add_run(1'b0, 2, 1'b0);
        // Glitch of 3 cycles: rejected.
        add_run(1'b1, 3, 1'b0); add_run(1'b0, 8, 1'b0);
        // Bounce 1,0,1,0 then settle high: one rise 5 edges after settling.
        add_one(1'b1, 1'b0, 1'b0, 1'b0); add_one(1'b0, 1'b0, 1'b0, 1'b0);
        add_one(1'b1, 1'b0, 1'b0, 1'b0); add_one(1'b0, 1'b0, 1'b0, 1'b0);
        add_run(1'b1, 5, 1'b0); add_one(1'b1, 1'b1, 1'b1, 1'b0); add_run(1'b1, 2, 1'b1);
        // Release again back to idle.
        add_run(1'b0, 5, 1'b1); add_one(1'b0, 1'b0, 1'b0, 1'b1); add_run(1'b0, 2, 1'b0);

        // Reset
        reset_n = 1'b0;
        press(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        check("reset.state", dbg_state, STABLE_LO);
        reset_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            press(vecs[i].btn);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_level, vecs[i].exp_rise, vecs[i].exp_fall);
        end

        // Reset mid CHK_HI: press held, reset once cnt has reached 2 (after edge 3).
        press(1'b1);
        repeat (4) step();
        check("midchk.state_before", dbg_state, CHK_HI);
        reset_n = 1'b0;
        #1;
        check_outs("midchk.in_reset", 1'b0, 1'b0, 1'b0);
        check("midchk.state_reset", dbg_state, STABLE_LO);
        repeat (2) step();
        check_outs("midchk.held_reset", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_outs($sformatf("post_reset_e%0d", k), (k >= 5), (k == 5), 1'b0);
        end

        // Reset while level is high: clears asynchronously, no strobe after release.
        reset_n = 1'b0;
        #1;
        check_outs("hi_reset", 1'b0, 1'b0, 1'b0);
        press(1'b0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_outs($sformatf("idle_after_reset_e%0d", k), 1'b0, 1'b0, 1'b0);
        end

        // Report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
